// File: rtl/dcache_ctrl_pkg.sv
// Shared encodings for the data-cache request controller: FSM states,
// access-size codes, load funct3 codes and the alignment check.
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] WLEN_B = 2'd0;
  localparam logic [1:0] WLEN_H = 2'd1;
  localparam logic [1:0] WLEN_W = 2'd2;
  localparam logic [1:0] WLEN_D = 2'd3;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;

  // Only the low address bits below the access size matter; bytes never misalign.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] wlen);
    logic mis;
    mis = 1'b0;
    case (wlen)
      WLEN_B:  mis = 1'b0;
      WLEN_H:  mis = addr_lo[0];
      WLEN_W:  mis = |addr_lo[1:0];
      WLEN_D:  mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dcache_load_ext.sv
// Combinational load-data extension: selects sign/zero extension of the
// right-aligned dcache data according to the load funct3.
module dcache_load_ext
  import dcache_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] raw_data,
  output logic [63:0] result
);

  always_comb begin
    result = '0;
    case (funct3)
      FUNCT3_LB:  result = {{56{raw_data[7]}},  raw_data[7:0]};
      FUNCT3_LH:  result = {{48{raw_data[15]}}, raw_data[15:0]};
      FUNCT3_LW:  result = {{32{raw_data[31]}}, raw_data[31:0]};
      FUNCT3_LD:  result = raw_data;
      FUNCT3_LBU: result = {56'd0, raw_data[7:0]};
      FUNCT3_LHU: result = {48'd0, raw_data[15:0]};
      FUNCT3_LWU: result = {32'd0, raw_data[31:0]};
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Load/store controller between decode and the data cache: latches one
// request, handshakes it with the dcache and writes back extended load data.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_wen_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [1:0]  req_wlen_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [4:0]  req_rd_addr_i,
  output logic        dc_valid_o,
  input  logic        dc_ready_i,
  output logic        dc_wen_o,
  output logic [63:0] dc_addr_o,
  output logic [63:0] dc_wdata_o,
  output logic [1:0]  dc_wlen_o,
  input  logic        dc_rvalid_i,
  input  logic [63:0] dc_rdata_i,
  output logic        stall_o,
  output logic        ld_valid_o,
  output logic [63:0] ld_data_o,
  output logic [4:0]  ld_rd_addr_o,
  output logic        misalign_o
);

  state_e      state_reg, state_next;
  logic        wen_reg;
  logic [63:0] addr_reg;
  logic [63:0] wdata_reg;
  logic [1:0]  wlen_reg;
  logic [2:0]  funct3_reg;
  logic [4:0]  rd_addr_reg;
  logic        ld_valid_reg, ld_valid_next;
  logic        misalign_reg, misalign_next;
  logic [63:0] ld_data_reg;
  logic [4:0]  ld_rd_addr_reg;
  logic        latch_req;
  logic        capture_ld;
  logic [63:0] ext_data;

  dcache_load_ext u_load_ext (
    .funct3   (funct3_reg),
    .raw_data (dc_rdata_i),
    .result   (ext_data)
  );

  always_comb begin
    state_next    = state_reg;
    stall_o       = 1'b0;
    dc_valid_o    = 1'b0;
    latch_req     = 1'b0;
    capture_ld    = 1'b0;
    ld_valid_next = 1'b0;
    misalign_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          stall_o   = 1'b1;
          latch_req = 1'b1;
          if (is_misaligned(req_addr_i[2:0], req_wlen_i)) begin
            misalign_next = 1'b1;
            state_next    = ST_DONE;
          end else begin
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_o    = 1'b1;
        dc_valid_o = 1'b1;
        if (dc_ready_i) state_next = ST_RESP;
      end
      ST_RESP: begin
        stall_o = 1'b1;
        if (dc_rvalid_i) begin
          state_next    = ST_DONE;
          ld_valid_next = ~wen_reg;
          capture_ld    = ~wen_reg;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      wen_reg        <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wlen_reg       <= '0;
      funct3_reg     <= '0;
      rd_addr_reg    <= '0;
      ld_valid_reg   <= 1'b0;
      misalign_reg   <= 1'b0;
      ld_data_reg    <= '0;
      ld_rd_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ld_valid_reg <= ld_valid_next;
      misalign_reg <= misalign_next;
      if (latch_req) begin
        wen_reg     <= req_wen_i;
        addr_reg    <= req_addr_i;
        wdata_reg   <= req_wdata_i;
        wlen_reg    <= req_wlen_i;
        funct3_reg  <= req_funct3_i;
        rd_addr_reg <= req_rd_addr_i;
      end
      // Writeback data only changes on a completed load, so it holds across stores.
      if (capture_ld) begin
        ld_data_reg    <= ext_data;
        ld_rd_addr_reg <= rd_addr_reg;
      end
    end
  end

  assign dc_wen_o     = wen_reg;
  assign dc_addr_o    = addr_reg;
  assign dc_wdata_o   = wdata_reg;
  assign dc_wlen_o    = wlen_reg;
  assign ld_valid_o   = ld_valid_reg;
  assign ld_data_o    = ld_data_reg;
  assign ld_rd_addr_o = ld_rd_addr_reg;
  assign misalign_o   = misalign_reg;

endmodule
